// File: rtl/aap_pipeline_pkg.sv
// Shared constants and the fetch FSM state encoding for the AAP pipeline.
// Every instruction word is 16 bits. The decoder sees a 32-bit slot.
package aap_pipeline_pkg;

    localparam int INSTR_W        = 16;
    localparam int DEC_W          = 32;
    localparam int INSTR_LONG_BIT = 15;

    typedef enum logic [1:0] {
        FETCH_LO = 2'd0,
        FETCH_HI = 2'd1,
        PRESENT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads 16-bit words from imem, assembles
// short (16-bit) and long (32-bit) instructions and offers them to the decoder.
module fetch_sequencer
    import aap_pipeline_pkg::*;
#(
    parameter int              PC_W     = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               dec_valid,
    output logic [DEC_W-1:0]   dec_instr,
    output logic               dec_long,
    output logic [PC_W-1:0]    dec_pc,
    input  logic               dec_ready
);

    fetch_state_e         state_q;
    logic [PC_W-1:0]      pc_q;
    logic [INSTR_W-1:0]   lo_word_q;
    logic                 dec_valid_q;
    logic [DEC_W-1:0]     dec_instr_q;
    logic                 dec_long_q;
    logic [PC_W-1:0]      dec_pc_q;

    logic [PC_W-1:0]      pc_plus_one;
    logic [PC_W-1:0]      pc_plus_two;
    logic                 ack_taken;

    // Additions truncate to PC_W, so a long instruction at all-ones takes its high word from 0.
    assign pc_plus_one = pc_q + PC_W'(1);
    assign pc_plus_two = pc_q + PC_W'(2);

    assign imem_req  = reset && !stall && (state_q != PRESENT);
    assign imem_addr = (state_q == FETCH_HI) ? pc_plus_one : pc_q;
    assign ack_taken = imem_ack && imem_req;

    assign dec_valid = dec_valid_q;
    assign dec_instr = dec_instr_q;
    assign dec_long  = dec_long_q;
    assign dec_pc    = dec_pc_q;

    // A redirect outranks everything else. It discards partial fetches, same-cycle
    // acks and same-cycle decoder handshakes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH_LO;
            pc_q        <= RESET_PC;
            lo_word_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_long_q  <= 1'b0;
            dec_pc_q    <= '0;
        end else if (redirect_valid) begin
            state_q     <= FETCH_LO;
            pc_q        <= redirect_pc;
            lo_word_q   <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_LO: begin
                    if (ack_taken) begin
                        lo_word_q <= imem_rdata;
                        if (imem_rdata[INSTR_LONG_BIT]) begin
                            state_q <= FETCH_HI;
                        end else begin
                            dec_instr_q <= {{(DEC_W-INSTR_W){1'b0}}, imem_rdata};
                            dec_long_q  <= 1'b0;
                            dec_pc_q    <= pc_q;
                            dec_valid_q <= 1'b1;
                            state_q     <= PRESENT;
                        end
                    end
                end
                FETCH_HI: begin
                    if (ack_taken) begin
                        dec_instr_q <= {imem_rdata, lo_word_q};
                        dec_long_q  <= 1'b1;
                        dec_pc_q    <= pc_q;
                        dec_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (dec_ready) begin
                        dec_valid_q <= 1'b0;
                        pc_q        <= dec_long_q ? pc_plus_two : pc_plus_one;
                        state_q     <= FETCH_LO;
                    end
                end
                default: begin
                    state_q <= FETCH_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Expected values are hand-computed
// from the fetch protocol.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [23:0] redirect_pc;
    logic        stall;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic        dec_long;
    logic [23:0] dec_pc;
    logic        dec_ready;

    int nChecks = 0;
    int nFail   = 0;

    fetch_sequencer #(.PC_W(24), .RESET_PC(24'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_long       (dec_long),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic ack, input logic [15:0] rdata, input logic redir,
                                 input logic [23:0] rpc, input logic stl, input logic rdy);
        imem_ack       = ack;
        imem_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        stall          = stl;
        dec_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkPresent(input string tag, input logic [31:0] instr, input logic lng,
                                input logic [23:0] pc);
        checkOutput({tag, "_valid"}, {31'b0, dec_valid}, 32'd1);
        checkOutput({tag, "_instr"}, dec_instr, instr);
        checkOutput({tag, "_long"}, {31'b0, dec_long}, {31'b0, lng});
        checkOutput({tag, "_pc"}, {8'h0, dec_pc}, {8'h0, pc});
        checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0);

        // 1: reset held for 3 cycles, then released
        repeat (3) cycle();
        checkOutput("rst_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("rst_instr", dec_instr, 32'h0);
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_addr", {8'h0, imem_addr}, 32'h0);
        reset = 1'b1;
        cycle();
        checkOutput("rel_req", {31'b0, imem_req}, 32'd1);
        checkOutput("rel_addr", {8'h0, imem_addr}, 32'h0);

        // 2: short instruction at address 0
        applyStimulus(1'b1, 16'h5555, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        checkPresent("short0", 32'h0000_5555, 1'b0, 24'h0);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checkOutput("short0_next_addr", {8'h0, imem_addr}, 32'h1);
        checkOutput("short0_done_valid", {31'b0, dec_valid}, 32'd0);

        // 3: long instruction at address 4
        applyStimulus(1'b0, 16'h0, 1'b1, 24'h4, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 16'h8001, 1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("redir4_addr", {8'h0, imem_addr}, 32'h4);
        cycle();
        checkOutput("long4_hi_addr", {8'h0, imem_addr}, 32'h5);
        checkOutput("long4_hi_valid", {31'b0, dec_valid}, 32'd0);
        imem_rdata = 16'h1234;
        cycle();
        imem_ack = 1'b0;
        checkPresent("long4", 32'h1234_8001, 1'b1, 24'h4);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checkOutput("long4_next_addr", {8'h0, imem_addr}, 32'h6);

        // 4: decoder back-pressure, then stall with acks that must be ignored
        applyStimulus(1'b1, 16'h0042, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkPresent($sformatf("hold%0d", i), 32'h0000_0042, 1'b0, 24'h6);
        end
        dec_ready = 1'b1;
        cycle();
        applyStimulus(1'b1, 16'h7777, 1'b0, 24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput($sformatf("stall%0d_req", i), {31'b0, imem_req}, 32'd0);
            checkOutput($sformatf("stall%0d_valid", i), {31'b0, dec_valid}, 32'd0);
            checkOutput($sformatf("stall%0d_addr", i), {8'h0, imem_addr}, 32'h7);
        end
        applyStimulus(1'b1, 16'h0011, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        imem_ack = 1'b0;
        checkPresent("after_stall", 32'h0000_0011, 1'b0, 24'h7);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checkOutput("after_stall_next", {8'h0, imem_addr}, 32'h8);

        // 5: redirect during FETCH_HI with a same-cycle ack
        applyStimulus(1'b1, 16'h8ABC, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        checkOutput("redir_hi_addr", {8'h0, imem_addr}, 32'h9);
        applyStimulus(1'b1, 16'h5678, 1'b1, 24'h100, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("redir_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("redir_addr", {8'h0, imem_addr}, 32'h100);
        checkOutput("redir_req", {31'b0, imem_req}, 32'd1);
        cycle();
        checkOutput("redir_valid2", {31'b0, dec_valid}, 32'd0);

        // Redirect wins over a same-cycle decoder handshake
        applyStimulus(1'b1, 16'h0022, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        checkPresent("pre_redir", 32'h0000_0022, 1'b0, 24'h100);
        applyStimulus(1'b0, 16'h0, 1'b1, 24'h200, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("redir_hs_addr", {8'h0, imem_addr}, 32'h200);
        checkOutput("redir_hs_valid", {31'b0, dec_valid}, 32'd0);

        // 6: wrap at the top of the address space
        applyStimulus(1'b0, 16'h0, 1'b1, 24'hFF_FFFF, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 16'h0001, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        imem_ack = 1'b0;
        checkPresent("wrap_short", 32'h0000_0001, 1'b0, 24'hFF_FFFF);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checkOutput("wrap_short_next", {8'h0, imem_addr}, 32'h0);
        applyStimulus(1'b0, 16'h0, 1'b1, 24'hFF_FFFF, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 16'h8002, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        checkOutput("wrap_long_hi_addr", {8'h0, imem_addr}, 32'h0);
        imem_rdata = 16'h0003;
        cycle();
        imem_ack = 1'b0;
        checkPresent("wrap_long", 32'h0003_8002, 1'b1, 24'hFF_FFFF);
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        checkOutput("wrap_long_next", {8'h0, imem_addr}, 32'h1);

        // Reset in the middle of a long fetch
        applyStimulus(1'b1, 16'h8005, 1'b0, 24'h0, 1'b0, 1'b0);
        cycle();
        imem_ack = 1'b0;
        checkOutput("mid_hi_addr", {8'h0, imem_addr}, 32'h2);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("mid_rst_addr", {8'h0, imem_addr}, 32'h0);
        checkOutput("mid_rst_instr", dec_instr, 32'h0);
        checkOutput("mid_rst_long", {31'b0, dec_long}, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", {8'h0, imem_addr}, 32'h0);
        checkOutput("post_rst_valid", {31'b0, dec_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
